// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit register block.
// Holds the transmit FSM state encoding, the LSR bit positions and the IIR codes.
package uart_pkg;

    // Transmit shifter states. PARITY is only reachable when UART_TX_PARITY_EN is defined.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Line status register bit positions driven by the transmitter.
    localparam int LSR_THRE = 5;
    localparam int LSR_TEMT = 6;

    // Interrupt identification codes.
    localparam logic [7:0] IIR_NONE = 8'h01;
    localparam logic [7:0] IIR_THRE = 8'h02;

endpackage

// File: rtl/uart_tx_shifter.sv
// uart_tx_shifter: serialises one byte as start, 8 data bits LSB first, optional even parity,
// and a stop bit. Build option UART_TX_PARITY_EN inserts the PARITY state before STOP.
//
// Load handshake: a byte transfers on any cycle where i_load_valid and o_load_ready are
// both 1. o_load_ready never depends on i_load_valid; it is high in IDLE and on the final
// tick of the stop bit, which gives back-to-back frames without an idle bit.
module uart_tx_shifter
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       i_clear,
    input  logic       i_hold,
    input  logic       i_tick,
    input  logic       i_load_valid,
    input  logic [7:0] i_load_data,
    output logic       o_load_ready,
    output logic       o_txd,
    output logic [2:0] o_state_next
);

    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);

    localparam logic [2:0] S_IDLE   = 3'(IDLE);
    localparam logic [2:0] S_START  = 3'(START);
    localparam logic [2:0] S_DATA   = 3'(DATA);
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'(PARITY);
`endif
    localparam logic [2:0] S_STOP   = 3'(STOP);

    logic [2:0]    r_state;
    logic [CW-1:0] r_bit_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic          r_txd;

    logic [2:0]    w_state_next;
    logic [CW-1:0] w_cnt_next;
    logic [2:0]    w_idx_next;
    logic [7:0]    w_shift_next;
    logic          w_txd_next;
    logic          w_bit_end;
    logic          w_load;

`ifdef UART_TX_PARITY_EN
    logic          r_par;
    logic          w_par_next;
`endif

    assign w_bit_end    = i_tick && (r_bit_cnt == LAST_TICK);
    assign o_load_ready = ~i_hold & ~i_clear &
                          ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));
    assign w_load       = o_load_ready & i_load_valid;
    assign o_state_next = i_clear ? S_IDLE : w_state_next;
    assign o_txd        = r_txd;

    // Next-state logic: bit timing, bit sequencing and the load of a new byte.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_bit_cnt;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
`ifdef UART_TX_PARITY_EN
        w_par_next   = r_par;
`endif
        if (!i_hold) begin
            if (i_tick && (r_state != S_IDLE)) begin
                w_cnt_next = w_bit_end ? '0 : r_bit_cnt + CW'(1);
            end
            case (r_state)
                S_START: begin
                    if (w_bit_end) begin
                        w_state_next = S_DATA;
                        w_idx_next   = 3'd0;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        w_shift_next = {1'b0, r_shift[7:1]};
                        if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            w_state_next = S_PARITY;
`else
                            w_state_next = S_STOP;
`endif
                        end else begin
                            w_idx_next = r_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        w_state_next = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: ;
            endcase
            // A load overrides the stop-to-idle move so the next start bit follows directly.
            if (w_load) begin
                w_state_next = S_START;
                w_cnt_next   = '0;
                w_shift_next = i_load_data;
`ifdef UART_TX_PARITY_EN
                w_par_next   = ^i_load_data;
`endif
            end
        end
    end

    // Line level for the coming cycle, taken from the state being entered.
    always_comb begin
        w_txd_next = 1'b1;
        case (w_state_next)
            S_START:  w_txd_next = 1'b0;
            S_DATA:   w_txd_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_txd_next = w_par_next;
`endif
            default:  w_txd_next = 1'b1;
        endcase
    end

    // Shifter registers; a clear aborts any frame and returns the line to idle high.
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_idx     <= 3'd0;
            r_shift   <= 8'h00;
            r_txd     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_cnt_next;
            r_idx     <= w_idx_next;
            r_shift   <= w_shift_next;
            r_txd     <= w_txd_next;
`ifdef UART_TX_PARITY_EN
            r_par     <= w_par_next;
`endif
        end
    end

endmodule

// File: rtl/uart_tx_register.sv
// uart_tx_register: transmit holding register, LSR transmitter bits and THRE interrupt.
// Build option UART_TX_PARITY_EN adds an even parity bit to every frame.
module uart_tx_register
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       WR,
    input  logic       IIR_RD,
    input  logic [7:0] DataIn,
    input  logic [7:0] IER,
    input  logic [7:0] FCR,
    input  logic       baud_tick,
    output logic       TxD,
    output logic [7:0] LSR,
    output logic [7:0] IIR
);

    logic [7:0] r_thr;
    logic       r_thr_full;
    logic [7:0] r_lsr;
    logic [7:0] r_iir;

    logic       w_clear;
    logic       w_hold;
    logic       w_load_ready;
    logic       w_load;
    logic       w_wr_accept;
    logic       w_full_next;
    logic [2:0] w_state_next;
    logic [7:0] w_lsr_next;
    logic       w_thre_rise;
    logic       w_txd;
    logic       w_unused;

    // Transmitter reset through FCR[2] behaves like the pin reset unless FCR[0] freezes the block.
    assign w_clear = ~reset | (FCR[2] & ~FCR[0]);
    assign w_hold  = FCR[0];

    assign w_load      = w_load_ready & r_thr_full;
    // A write is taken when THR is empty or is being emptied by a load in the same cycle.
    assign w_wr_accept = WR & ~w_hold & (~r_thr_full | w_load);
    assign w_full_next = w_wr_accept ? 1'b1 : (w_load ? 1'b0 : r_thr_full);
    assign w_thre_rise = ~r_lsr[LSR_THRE] & w_lsr_next[LSR_THRE];

    assign w_unused = ^{FCR[7:3], FCR[1], IER[7:2], IER[0]};

    assign TxD = w_txd;
    assign LSR = r_lsr;
    assign IIR = r_iir;

    uart_tx_shifter #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_shifter (
        .clk          (clk),
        .i_clear      (w_clear),
        .i_hold       (w_hold),
        .i_tick       (baud_tick),
        .i_load_valid (r_thr_full),
        .i_load_data  (r_thr),
        .o_load_ready (w_load_ready),
        .o_txd        (w_txd),
        .o_state_next (w_state_next)
    );

    // LSR value for the coming cycle, so it tracks THR occupancy and shifter state.
    always_comb begin
        w_lsr_next           = 8'h00;
        w_lsr_next[LSR_THRE] = ~w_full_next;
        w_lsr_next[LSR_TEMT] = ~w_full_next & (w_state_next == 3'(IDLE));
    end

    // Transmit holding register and its occupancy flag.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_thr      <= 8'h00;
            r_thr_full <= 1'b0;
        end else if (!w_hold) begin
            if (w_wr_accept) begin
                r_thr <= DataIn;
            end
            r_thr_full <= w_full_next;
        end
    end

    // Registered line status bits.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_lsr <= 8'h60;
        end else if (!w_hold) begin
            r_lsr <= w_lsr_next;
        end
    end

    // THRE interrupt: raised when THR becomes empty, a raise beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_iir <= IIR_NONE;
        end else if (!w_hold) begin
            if (!IER[1]) begin
                r_iir <= IIR_NONE;
            end else if (w_thre_rise) begin
                r_iir <= IIR_THRE;
            end else if (WR || IIR_RD) begin
                r_iir <= IIR_NONE;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_register.sv
// tb_uart_tx_register: directed bench for uart_tx_register with OVERSAMPLE=16.
// TxD and LSR[6] are sampled on every baud tick; frames are decoded from those samples.
module tb_uart_tx_register;

    localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       WR;
    logic       IIR_RD;
    logic [7:0] DataIn;
    logic [7:0] IER;
    logic [7:0] FCR;
    logic       baud_tick;
    logic       TxD;
    logic [7:0] LSR;
    logic [7:0] IIR;

    int total = 0;
    int bad   = 0;

    logic       tx_q[$];
    logic       temt_q[$];
    logic [0:0] exp_q[$];

    uart_tx_register #(
        .OVERSAMPLE (OS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .WR        (WR),
        .IIR_RD    (IIR_RD),
        .DataIn    (DataIn),
        .IER       (IER),
        .FCR       (FCR),
        .baud_tick (baud_tick),
        .TxD       (TxD),
        .LSR       (LSR),
        .IIR       (IIR)
    );

    // Clock and baud tick (one tick every 4 clocks).
    always #5 clk = ~clk;

    initial begin
        int div;
        div = 0;
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            div = (div + 1) % 4;
            baud_tick = (div == 0);
        end
    end

    // Line monitor: one sample per baud tick, taken away from the active edge.
    always @(negedge clk) begin
        if (baud_tick) begin
            tx_q.push_back(TxD);
            temt_q.push_back(LSR[6]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        tx_q.delete();
        temt_q.delete();
    endtask

    task automatic wr(input logic [7:0] b);
        @(posedge clk);
        #1;
        WR     = 1'b1;
        DataIn = b;
        @(posedge clk);
        #1;
        WR = 1'b0;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int max_clks);
        int n;
        n = 0;
        while (LSR !== 8'h60 && n < max_clks) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_in_time"}, (LSR === 8'h60), 1);
    endtask

    // Expected slot levels: start, 8 data LSB first, optional even parity, stop.
    task automatic build_exp(input logic [7:0] b);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        exp_q.push_back(^b);
`endif
        exp_q.push_back(1'b1);
    endtask

    function automatic int find_start(input int from);
        for (int i = from; i < tx_q.size(); i++) begin
            if (tx_q[i] == 1'b0) return i;
        end
        return -1;
    endfunction

    function automatic int count_zeros(input int from);
        int n;
        n = 0;
        for (int i = from; i < tx_q.size(); i++) if (tx_q[i] == 1'b0) n++;
        return n;
    endfunction

    function automatic int count_temt_low(input int from);
        int n;
        n = 0;
        for (int i = from; i < temt_q.size(); i++) if (temt_q[i] == 1'b0) n++;
        return n;
    endfunction

    // Every slot must hold its level for all OS ticks.
    task automatic check_frame(input string tag, input logic [7:0] b, input int s);
        int ones;
        build_exp(b);
        for (int k = 0; k < NB; k++) begin
            ones = 0;
            for (int j = 0; j < OS; j++) begin
                if (s + k * OS + j < tx_q.size()) ones += int'(tx_q[s + k * OS + j]);
            end
            chk($sformatf("%s_slot%0d", tag, k), ones, exp_q[k] ? OS : 0);
        end
    endtask

    initial begin
        int s1;
        int s2;
        reset  = 1'b0;
        WR     = 1'b0;
        IIR_RD = 1'b0;
        DataIn = 8'h00;
        IER    = 8'h00;
        FCR    = 8'h00;

        // Reset and idle state.
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_txd", TxD, 1'b1);
        chk("rst_lsr", LSR, 8'h60);
        chk("rst_iir", IIR, 8'h01);

        // Single frame 8'hA5.
        clear_mon();
        wr(8'hA5);
        chk("a5_lsr_full", LSR, 8'h00);
        wait_clks(1);
        chk("a5_txd_fall", TxD, 1'b0);
        chk("a5_lsr_busy", LSR, 8'h20);
        wait_clks(200);
        chk("a5_lsr_mid", LSR, 8'h20);
        wait_idle("a5", 2000);
        s1 = find_start(0);
        chk("a5_found", (s1 >= 0), 1);
        if (s1 >= 0) begin
            check_frame("a5", 8'hA5, s1);
            chk("a5_len", count_temt_low(s1), OS * NB);
        end
        chk("a5_txd_after", TxD, 1'b1);
        chk("a5_lsr_after", LSR, 8'h60);

        // Back-to-back frames, third write dropped while THR is full.
        clear_mon();
        wr(8'h55);
        wait_clks(10);
        wr(8'h0F);
        chk("b2b_lsr_full", LSR, 8'h00);
        wr(8'h99);
        wait_idle("b2b", 4000);
        s1 = find_start(0);
        chk("b2b_found1", (s1 >= 0), 1);
        if (s1 >= 0) begin
            check_frame("b2b_55", 8'h55, s1);
            s2 = find_start(s1 + OS * NB);
            chk("b2b_no_gap", s2, s1 + OS * NB);
            if (s2 >= 0) begin
                check_frame("b2b_0f", 8'h0F, s2);
                chk("b2b_third_absent", count_zeros(s2 + OS * NB), 0);
            end
            chk("b2b_len", count_temt_low(s1), 2 * OS * NB);
        end

        // THRE interrupt raised on the load, cleared by an IIR read.
        IER = 8'h02;
        wait_clks(2);
        chk("irq_pre", IIR, 8'h01);
        wr(8'h33);
        chk("irq_after_wr", IIR, 8'h01);
        wait_clks(1);
        chk("irq_set", IIR, 8'h02);
        wait_clks(5);
        chk("irq_held", IIR, 8'h02);
        IIR_RD = 1'b1;
        wait_clks(1);
        IIR_RD = 1'b0;
        chk("irq_read_clr", IIR, 8'h01);
        wait_idle("irq", 2000);
        chk("irq_end", IIR, 8'h01);
        IER = 8'h00;

        // Pin reset in the middle of the data bits.
        clear_mon();
        wr(8'h00);
        wait_clks(150);
        chk("rst_mid_pre_txd", TxD, 1'b0);
        reset = 1'b0;
        wait_clks(1);
        reset = 1'b1;
        chk("rst_mid_txd", TxD, 1'b1);
        chk("rst_mid_lsr", LSR, 8'h60);
        clear_mon();
        wait_clks(800);
        chk("rst_mid_no_frame", count_zeros(0), 0);

        // Transmitter reset via FCR[2] in the middle of the data bits.
        wr(8'h00);
        wait_clks(150);
        chk("fcr_mid_pre_txd", TxD, 1'b0);
        FCR = 8'h04;
        wait_clks(1);
        FCR = 8'h00;
        chk("fcr_mid_txd", TxD, 1'b1);
        chk("fcr_mid_lsr", LSR, 8'h60);
        clear_mon();
        wait_clks(800);
        chk("fcr_mid_no_frame", count_zeros(0), 0);

        // FCR[0] freezes the block and drops writes.
        FCR = 8'h01;
        wr(8'h12);
        wait_clks(5);
        chk("hold_lsr", LSR, 8'h60);
        FCR = 8'h00;
        clear_mon();
        wait_clks(200);
        chk("hold_no_frame", count_zeros(0), 0);

        // Frame length and parity with 8'h07.
        clear_mon();
        wr(8'h07);
        wait_idle("p07", 2000);
        s1 = find_start(0);
        chk("p07_found", (s1 >= 0), 1);
        if (s1 >= 0) begin
            check_frame("p07", 8'h07, s1);
            chk("p07_len", count_temt_low(s1), OS * NB);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Overall time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
